// File: rtl/avl_arbiter.sv
// Two-port (fetch/data) request arbiter in front of the Avalon-MM bridge.
// One pending request buffered per port, one transaction outstanding downstream.
module avl_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        avl_valid,
  output logic        avl_instr,
  output logic [31:0] avl_addr,
  output logic [31:0] avl_wdata,
  output logic [3:0]  avl_wstrb,
  input  logic [31:0] avl_rdata,
  input  logic        avl_ready
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nx;
  logic        owner, last_grant;   // 0 = imem, 1 = dmem
  logic        live;                // low for the first cycle after reset
  logic        ibuf_full, dbuf_full;
  logic [31:0] ibuf_addr, dbuf_addr, dbuf_wdata;
  logic [3:0]  dbuf_wstrb;
  logic        en, i_cand, d_cand, grant, issue, i_issue, d_issue, done, i_cap, d_cap;

  assign en      = rst & live;
  assign i_cand  = ibuf_full | imem_valid;
  assign d_cand  = dbuf_full | dmem_valid;
  // dmem wins when it is the only candidate, or on a tie when imem went last
  assign grant   = d_cand & (~i_cand | ~last_grant);
  assign issue   = en & (state == IDLE) & (i_cand | d_cand);
  assign i_issue = issue & ~grant;
  assign d_issue = issue & grant;
  assign done    = en & (state == BUSY) & avl_ready;

  // Live input is captured unless it goes straight out; a full buffer only
  // accepts it when that buffer is being issued this cycle.
  assign i_cap = imem_valid & ~(i_issue & ~ibuf_full) & (~ibuf_full | i_issue);
  assign d_cap = dmem_valid & ~(d_issue & ~dbuf_full) & (~dbuf_full | d_issue);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (issue) state_nx = BUSY;
      BUSY: if (done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    avl_valid  = issue;
    avl_instr  = 1'b0;
    avl_addr   = '0;
    avl_wdata  = '0;
    avl_wstrb  = '0;
    if (i_issue) begin
      avl_instr = 1'b1;
      avl_addr  = ibuf_full ? ibuf_addr : imem_addr;
    end else if (d_issue) begin
      avl_addr  = dbuf_full ? dbuf_addr  : dmem_addr;
      avl_wdata = dbuf_full ? dbuf_wdata : dmem_wdata;
      avl_wstrb = dbuf_full ? dbuf_wstrb : dmem_wstrb;
    end
    imem_ready = done & ~owner;
    dmem_ready = done & owner;
    imem_rdata = imem_ready ? avl_rdata : '0;
    dmem_rdata = dmem_ready ? avl_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      live       <= 1'b0;
      ibuf_full  <= 1'b0;
      ibuf_addr  <= '0;
      dbuf_full  <= 1'b0;
      dbuf_addr  <= '0;
      dbuf_wdata <= '0;
      dbuf_wstrb <= '0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
      if (issue) begin
        owner      <= grant;
        last_grant <= grant;
      end
      if (i_cap) begin
        ibuf_full <= 1'b1;
        ibuf_addr <= imem_addr;
      end else if (i_issue) begin
        ibuf_full <= 1'b0;
      end
      if (d_cap) begin
        dbuf_full  <= 1'b1;
        dbuf_addr  <= dmem_addr;
        dbuf_wdata <= dmem_wdata;
        dbuf_wstrb <= dmem_wstrb;
      end else if (d_issue) begin
        dbuf_full <= 1'b0;
      end
    end
  end

  // A new request into an occupied buffer is dropped by the logic above.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(imem_valid && ibuf_full && !i_issue));
      assert (!(dmem_valid && dbuf_full && !d_issue));
    end
  end
endmodule

// File: tb/tb_avl_arbiter.sv
// Randomized scoreboard bench for avl_arbiter: queue-based reference model
// predicts issue order/cycle and response routing; a monitor compares.
module tb_avl_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid, dmem_valid, avl_ready;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, avl_rdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] imem_rdata, dmem_rdata, avl_addr, avl_wdata;
  logic        imem_ready, dmem_ready, avl_valid, avl_instr;
  logic [3:0]  avl_wstrb;

  avl_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .avl_valid(avl_valid), .avl_instr(avl_instr), .avl_addr(avl_addr), .avl_wdata(avl_wdata),
    .avl_wstrb(avl_wstrb), .avl_rdata(avl_rdata), .avl_ready(avl_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct { int cyc; logic instr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } avl_t;
  typedef struct { int cyc; bit port; logic [31:0] rdata; } resp_t;

  req_t  pend_i[$], pend_d[$];
  avl_t  exp_avl[$];
  resp_t exp_resp[$];

  int   tests = 0, failed = 0, cyc = 0;
  bit   m_busy = 0, m_owner = 0, m_last = 0, force_both = 0;
  int   ready_at = 0;
  bit   out_p [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // mode 0: reset cycle, 1: first cycle after reset, 2: random traffic, 3: drain
  task automatic step(input int mode);
    req_t r;
    avl_t a;
    resp_t q;
    bit   g;
    @(negedge clk);
    cyc++;
    imem_valid = 0; dmem_valid = 0; avl_ready = 0;
    avl_rdata  = $urandom;
    imem_addr  = $urandom; dmem_addr = $urandom; dmem_wdata = $urandom;
    dmem_wstrb = 4'($urandom);
    rst = (mode != 0);
    if (mode < 2) begin
      avl_ready = 1;   // stale bridge ready around reset must be ignored
    end else begin
      if (m_busy && cyc == ready_at) begin
        avl_ready = 1;
        out_p[m_owner] = 0;
      end
      if (mode == 2) begin
        if (!out_p[0] && (force_both || $urandom_range(0, 2) == 0)) begin
          imem_valid = 1; out_p[0] = 1;
        end
        if (!out_p[1] && (force_both || $urandom_range(0, 2) == 0)) begin
          dmem_valid = 1; out_p[1] = 1;
        end
        force_both = 0;
      end
      if (!m_busy && pend_i.size() == 0 && pend_d.size() == 0 && !imem_valid && !dmem_valid
          && $urandom_range(0, 5) == 0)
        avl_ready = 1;
    end
    #1;
    if (mode == 0) begin
      pend_i.delete(); pend_d.delete();
      m_busy = 0; m_last = 0; out_p[0] = 0; out_p[1] = 0;
    end else begin
      if (imem_valid) begin r.addr = imem_addr; r.wdata = 0; r.wstrb = 0; pend_i.push_back(r); end
      if (dmem_valid) begin r.addr = dmem_addr; r.wdata = dmem_wdata; r.wstrb = dmem_wstrb; pend_d.push_back(r); end
      if (m_busy) begin
        if (avl_ready) begin
          q.cyc = cyc; q.port = m_owner; q.rdata = avl_rdata;
          exp_resp.push_back(q);
          m_busy = 0;
        end
      end else if (mode != 1 && (pend_i.size() + pend_d.size()) > 0) begin
        if (pend_i.size() > 0 && pend_d.size() > 0) g = !m_last;
        else g = (pend_d.size() > 0);
        if (g) begin
          r = pend_d.pop_front();
          a.instr = 0; a.addr = r.addr; a.wdata = r.wdata; a.wstrb = r.wstrb;
        end else begin
          r = pend_i.pop_front();
          a.instr = 1; a.addr = r.addr; a.wdata = 0; a.wstrb = 0;
        end
        a.cyc = cyc;
        exp_avl.push_back(a);
        m_busy = 1; m_owner = g; m_last = g;
        ready_at = cyc + int'($urandom_range(1, 3));
      end
    end
  endtask

  always begin
    avl_t  a;
    resp_t q;
    @(negedge clk);
    #2;
    if (avl_valid) begin
      if (exp_avl.size() == 0) begin
        tests++; failed++;
        $display("FAIL avl_unexpected cyc=%0d: got avl_valid=1 want 0", cyc);
      end else begin
        a = exp_avl.pop_front();
        chk("avl_issue_cycle", cyc, a.cyc);
        chk("avl_instr", {31'd0, avl_instr}, {31'd0, a.instr});
        chk("avl_addr", avl_addr, a.addr);
        chk("avl_wdata", avl_wdata, a.wdata);
        chk("avl_wstrb", {28'd0, avl_wstrb}, {28'd0, a.wstrb});
      end
    end else begin
      chk("avl_idle_zero", avl_addr | avl_wdata | {27'd0, avl_wstrb, avl_instr}, 0);
    end
    if (imem_ready && dmem_ready) begin
      tests++; failed++;
      $display("FAIL both_ready cyc=%0d: got 2 readies want at most 1", cyc);
    end else if (imem_ready || dmem_ready) begin
      if (exp_resp.size() == 0) begin
        tests++; failed++;
        $display("FAIL ready_unexpected cyc=%0d: got imem=%0b dmem=%0b want none", cyc, imem_ready, dmem_ready);
      end else begin
        q = exp_resp.pop_front();
        chk("resp_cycle", cyc, q.cyc);
        chk("resp_port", {31'd0, dmem_ready}, {31'd0, q.port});
        chk("resp_rdata", dmem_ready ? dmem_rdata : imem_rdata, q.rdata);
        chk("other_rdata_zero", dmem_ready ? imem_rdata : dmem_rdata, 0);
      end
    end else begin
      chk("rdata_idle_zero", imem_rdata | dmem_rdata, 0);
    end
  end

  initial begin
    bit pending_rst;
    rst = 0; imem_valid = 0; dmem_valid = 0; avl_ready = 0;
    imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0; avl_rdata = 0;
    out_p[0] = 0; out_p[1] = 0;
    pending_rst = 0;
    step(0); step(0); step(1);
    force_both = 1;
    for (int k = 0; k < 1500; k++) begin
      if (k == 500 || k == 1000) pending_rst = 1;
      if (pending_rst && m_busy) begin
        step(0); step(1);
        force_both = 1;
        pending_rst = 0;
      end else begin
        step(2);
      end
    end
    repeat (10) step(3);
    @(negedge clk);
    #3;
    chk("issues_outstanding", exp_avl.size(), 0);
    chk("responses_outstanding", exp_resp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
